// File: rtl/rvc_fetch_aligner_pkg.sv
// Shared constants for the RVC fetch aligner: halfword / instruction widths,
// instruction lengths in halfwords, the opcode-low pattern that marks a
// 32-bit instruction, and the PC step sizes.
package rvc_fetch_aligner_pkg;

   localparam int HW_W        = 16;
   localparam int INST_W      = 32;
   localparam int LEN_HW      = 1;
   localparam int LEN_FULL    = 2;
   localparam logic [1:0] OPC_FULL = 2'b11;
   localparam int PC_INC_HW   = 2;
   localparam int PC_INC_WORD = 4;

   // A halfword starts a 32-bit instruction when its two low bits are 2'b11.
   function automatic logic is_full(input logic [HW_W-1:0] hw);
      return hw[1:0] == OPC_FULL;
   endfunction

endpackage

// File: rtl/rvc_fetch_aligner_rvc_exp.sv
// RV32C expander: combinational translation of a 16-bit compressed instruction
// into its 32-bit equivalent. A 32-bit input (low bits 2'b11) passes through
// unchanged; unrecognised compressed encodings are passed through zero-extended.
// Ports:
//   i_instr  in  32  {upper, lower} halfwords; upper ignored for RVC
//   o_instr  out 32  expanded instruction
//   o_rd/o_rs1/o_rs2/o_rs3 out 5  register fields of the expanded instruction
module rvc_fetch_aligner_rvc_exp
   import rvc_fetch_aligner_pkg::*;
(
   input  logic [INST_W-1:0] i_instr,
   output logic [INST_W-1:0] o_instr,
   output logic [4:0]        o_rd,
   output logic [4:0]        o_rs1,
   output logic [4:0]        o_rs2,
   output logic [4:0]        o_rs3
);

   logic [HW_W-1:0] w_c;
   logic [4:0]      w_rd;
   logic [4:0]      w_rs2;
   logic [4:0]      w_rdp;
   logic [4:0]      w_rs1p;

   assign w_c    = i_instr[HW_W-1:0];
   assign w_rd   = w_c[11:7];
   assign w_rs2  = w_c[6:2];
   assign w_rdp  = {2'b01, w_c[4:2]};
   assign w_rs1p = {2'b01, w_c[9:7]};

   always_comb begin
      o_instr = i_instr;
      if (!is_full(w_c)) begin
         o_instr = {16'h0, w_c};
         case ({w_c[15:13], w_c[1:0]})
            5'b000_00: o_instr = {2'b00, w_c[10:7], w_c[12:11], w_c[5], w_c[6], 2'b00,
                                  5'd2, 3'b000, w_rdp, 7'b0010011};
            5'b010_00: o_instr = {5'b0, w_c[5], w_c[12:10], w_c[6], 2'b00,
                                  w_rs1p, 3'b010, w_rdp, 7'b0000011};
            5'b110_00: o_instr = {5'b0, w_c[5], w_c[12], w_rdp, w_rs1p, 3'b010,
                                  w_c[11:10], w_c[6], 2'b00, 7'b0100011};
            5'b000_01: o_instr = {{7{w_c[12]}}, w_c[6:2], w_rd, 3'b000, w_rd, 7'b0010011};
            5'b001_01,
            5'b101_01: o_instr = {w_c[12], w_c[8], w_c[10:9], w_c[6], w_c[7], w_c[2], w_c[11],
                                  w_c[5:3], w_c[12], {8{w_c[12]}},
                                  (w_c[15] ? 5'd0 : 5'd1), 7'b1101111};
            5'b010_01: o_instr = {{7{w_c[12]}}, w_c[6:2], 5'd0, 3'b000, w_rd, 7'b0010011};
            5'b011_01: begin
               if (w_rd == 5'd2)
                  o_instr = {{3{w_c[12]}}, w_c[4:3], w_c[5], w_c[2], w_c[6], 4'b0000,
                             5'd2, 3'b000, 5'd2, 7'b0010011};
               else
                  o_instr = {{15{w_c[12]}}, w_c[6:2], w_rd, 7'b0110111};
            end
            5'b100_01: begin
               case (w_c[11:10])
                  2'b00: o_instr = {7'b0000000, w_c[6:2], w_rs1p, 3'b101, w_rs1p, 7'b0010011};
                  2'b01: o_instr = {7'b0100000, w_c[6:2], w_rs1p, 3'b101, w_rs1p, 7'b0010011};
                  2'b10: o_instr = {{7{w_c[12]}}, w_c[6:2], w_rs1p, 3'b111, w_rs1p, 7'b0010011};
                  default: begin
                     if (!w_c[12]) begin
                        case (w_c[6:5])
                           2'b00:   o_instr = {7'b0100000, w_rdp, w_rs1p, 3'b000, w_rs1p, 7'b0110011};
                           2'b01:   o_instr = {7'b0000000, w_rdp, w_rs1p, 3'b100, w_rs1p, 7'b0110011};
                           2'b10:   o_instr = {7'b0000000, w_rdp, w_rs1p, 3'b110, w_rs1p, 7'b0110011};
                           default: o_instr = {7'b0000000, w_rdp, w_rs1p, 3'b111, w_rs1p, 7'b0110011};
                        endcase
                     end
                  end
               endcase
            end
            5'b110_01,
            5'b111_01: o_instr = {{4{w_c[12]}}, w_c[6:5], w_c[2], 5'd0, w_rs1p, {2'b00, w_c[13]},
                                  w_c[11:10], w_c[4:3], w_c[12], 7'b1100011};
            5'b000_10: o_instr = {7'b0000000, w_c[6:2], w_rd, 3'b001, w_rd, 7'b0010011};
            5'b010_10: o_instr = {4'b0, w_c[3:2], w_c[12], w_c[6:4], 2'b00,
                                  5'd2, 3'b010, w_rd, 7'b0000011};
            5'b100_10: begin
               if (!w_c[12]) begin
                  if (w_rs2 == 5'd0)
                     o_instr = {12'b0, w_rd, 3'b000, 5'd0, 7'b1100111};
                  else
                     o_instr = {7'b0, w_rs2, 5'd0, 3'b000, w_rd, 7'b0110011};
               end else begin
                  if (w_rs2 == 5'd0) begin
                     if (w_rd == 5'd0)
                        o_instr = 32'h0010_0073;
                     else
                        o_instr = {12'b0, w_rd, 3'b000, 5'd1, 7'b1100111};
                  end else begin
                     o_instr = {7'b0, w_rs2, w_rd, 3'b000, w_rd, 7'b0110011};
                  end
               end
            end
            5'b110_10: o_instr = {4'b0, w_c[8:7], w_c[12], w_rs2, 5'd2, 3'b010,
                                  w_c[11:9], 2'b00, 7'b0100011};
            default: ;
         endcase
      end
   end

   assign o_rd  = o_instr[11:7];
   assign o_rs1 = o_instr[19:15];
   assign o_rs2 = o_instr[24:20];
   assign o_rs3 = o_instr[31:27];

endmodule

// File: rtl/rvc_fetch_aligner.sv
// RVC fetch aligner: buffers word-aligned fetch words as halfwords and hands
// decode one instruction per cycle (16-bit RVC, expanded, or 32-bit, which may
// straddle two fetch words). Redirects flush the buffer; a redirect target with
// pc[1]=1 drops the low halfword of the next accepted word.
// Optional feature macro: RVC_PERF_CNT_EN adds retired RVC / 32-bit counters;
// without it the counter outputs are tied to zero.
// Ports:
//   clock, reset (async, active-low)
//   io_fetch_valid/ready/data/pc     fetch word input
//   io_redirect_valid/pc             flush and restart
//   io_inst_valid/ready              instruction handshake to decode
//   io_inst_bits/raw/pc/rvc          expanded bits, raw bits, PC, RVC flag
//   io_inst_rd/rs1/rs2/rs3           register fields
//   io_cnt_rvc/io_cnt_full           retired instruction counters
module rvc_fetch_aligner
   import rvc_fetch_aligner_pkg::*;
#(
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_fetch_valid,
   output logic              io_fetch_ready,
   input  logic [INST_W-1:0] io_fetch_data,
   input  logic [PC_W-1:0]   io_fetch_pc,
   input  logic              io_redirect_valid,
   input  logic [PC_W-1:0]   io_redirect_pc,
   output logic              io_inst_valid,
   input  logic              io_inst_ready,
   output logic [INST_W-1:0] io_inst_bits,
   output logic [INST_W-1:0] io_inst_raw,
   output logic [PC_W-1:0]   io_inst_pc,
   output logic              io_inst_rvc,
   output logic [4:0]        io_inst_rd,
   output logic [4:0]        io_inst_rs1,
   output logic [4:0]        io_inst_rs2,
   output logic [4:0]        io_inst_rs3,
   output logic [CNT_W-1:0]  io_cnt_rvc,
   output logic [CNT_W-1:0]  io_cnt_full
);

   logic [2:0][HW_W-1:0] r_hw;
   logic [1:0]           r_cnt;
   logic                 r_drop_lo;
   logic [PC_W-1:0]      r_head_pc;

   logic [2:0][HW_W-1:0] w_hw_nxt;
   logic [1:0]           w_cnt_nxt;
   logic                 w_drop_nxt;
   logic [PC_W-1:0]      w_pc_nxt;
   logic                 w_full;
   logic [1:0]           w_len;
   logic [1:0]           w_cnt_pop;
   logic                 w_pop;
   logic                 w_push;
   logic [INST_W-1:0]    w_exp_in;

   assign w_full = is_full(r_hw[0]);
   assign w_len  = w_full ? 2'(LEN_FULL) : 2'(LEN_HW);

   assign io_inst_valid  = (r_cnt >= w_len);
   assign io_fetch_ready = (r_cnt <= 2'd1);
   assign w_pop  = io_inst_valid && io_inst_ready;
   assign w_push = io_fetch_valid && io_fetch_ready;

   // Count after the pop shift; a push only happens from cnt<=1, so this is
   // at most 1 whenever the append below is active.
   assign w_cnt_pop = w_pop ? (r_cnt - w_len) : r_cnt;

   always_comb begin
      w_hw_nxt   = r_hw;
      w_cnt_nxt  = r_cnt;
      w_drop_nxt = r_drop_lo;
      w_pc_nxt   = r_head_pc;
      if (io_redirect_valid) begin
         w_cnt_nxt  = 2'd0;
         w_drop_nxt = io_redirect_pc[1];
         w_pc_nxt   = io_redirect_pc;
      end else begin
         if (w_pop) begin
            if (w_full)
               w_hw_nxt = {16'h0, 16'h0, r_hw[2]};
            else
               w_hw_nxt = {16'h0, r_hw[2], r_hw[1]};
            w_pc_nxt = r_head_pc + (w_full ? PC_W'(PC_INC_WORD) : PC_W'(PC_INC_HW));
         end
         w_cnt_nxt = w_cnt_pop;
         if (w_push) begin
            if (r_drop_lo) begin
               if (w_cnt_pop[0])
                  w_hw_nxt[1] = io_fetch_data[31:16];
               else
                  w_hw_nxt[0] = io_fetch_data[31:16];
               w_cnt_nxt = w_cnt_pop + 2'd1;
            end else begin
               if (w_cnt_pop[0])
                  w_hw_nxt[2:1] = io_fetch_data;
               else
                  w_hw_nxt[1:0] = io_fetch_data;
               w_cnt_nxt = w_cnt_pop + 2'd2;
            end
            if (w_cnt_pop == 2'd0)
               w_pc_nxt = io_fetch_pc + (r_drop_lo ? PC_W'(PC_INC_HW) : '0);
            w_drop_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_hw      <= '0;
         r_cnt     <= 2'd0;
         r_drop_lo <= 1'b0;
         r_head_pc <= '0;
      end else begin
         r_hw      <= w_hw_nxt;
         r_cnt     <= w_cnt_nxt;
         r_drop_lo <= w_drop_nxt;
         r_head_pc <= w_pc_nxt;
      end
   end

   assign w_exp_in    = w_full ? {r_hw[1], r_hw[0]} : {16'h0, r_hw[0]};
   assign io_inst_raw = w_exp_in;
   assign io_inst_pc  = r_head_pc;
   assign io_inst_rvc = !w_full;

   rvc_fetch_aligner_rvc_exp u_rvc_exp (
      .i_instr (w_exp_in),
      .o_instr (io_inst_bits),
      .o_rd    (io_inst_rd),
      .o_rs1   (io_inst_rs1),
      .o_rs2   (io_inst_rs2),
      .o_rs3   (io_inst_rs3)
   );

`ifdef RVC_PERF_CNT_EN
   logic [CNT_W-1:0] r_cnt_rvc;
   logic [CNT_W-1:0] r_cnt_full;

   // A pop killed by a same-cycle redirect does not retire.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt_rvc  <= '0;
         r_cnt_full <= '0;
      end else if (w_pop && !io_redirect_valid) begin
         if (w_full)
            r_cnt_full <= r_cnt_full + CNT_W'(1);
         else
            r_cnt_rvc  <= r_cnt_rvc + CNT_W'(1);
      end
   end

   assign io_cnt_rvc  = r_cnt_rvc;
   assign io_cnt_full = r_cnt_full;
`else
   assign io_cnt_rvc  = '0;
   assign io_cnt_full = '0;
`endif

endmodule
